// File: rtl/eve_pkg.sv
// Shared gene layout, sentinel genes and sequencer state encoding for the EvE crossover path.
// Pure definitions: no logic, no latency, no flow control.
package eve_pkg;
    localparam int GENE_W   = 64;
    localparam int ID_LSB   = 56;
    localparam int TYPE_BIT = 55;
    localparam int NODE_LSB = 40;
    localparam int CONN_LSB = 32;
    localparam int DATA_LSB = 0;

    localparam logic [7:0] INVALID_ID = 8'hFF;

    // Connection type with node FF so it sorts after every real gene in the engine.
    localparam logic [GENE_W-1:0] END_GENE = {INVALID_ID, 1'b1, 7'h7F, 8'hFF, 8'hFF, 32'h0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESYNC,
        ST_FETCH,
        ST_LOAD,
        ST_EVAL,
        ST_ADVANCE,
        ST_FINISH
    } seq_state_t;

    function automatic logic [7:0] gene_id(input logic [GENE_W-1:0] g);
        return g[ID_LSB +: 8];
    endfunction
endpackage

// File: rtl/eve_crossover_sequencer_if.sv
// Bundle of control, parent/child memory and engine signals around one crossover sequencer.
// master = sequencer side, slave = memories/engine/controller side.
interface eve_crossover_sequencer_if #(parameter int ADDR_W = 8);
    import eve_pkg::*;

    logic              start;
    logic [7:0]        child_id;
    logic [ADDR_W:0]   len_a;
    logic [ADDR_W:0]   len_b;
    logic              a_rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [GENE_W-1:0] a_rdata;
    logic              b_rd_en;
    logic [ADDR_W-1:0] b_addr;
    logic [GENE_W-1:0] b_rdata;
    logic              eng_rst;
    logic [7:0]        eng_id;
    logic [GENE_W-1:0] eng_parent_a;
    logic [GENE_W-1:0] eng_parent_b;
    logic              eng_read_a;
    logic              eng_read_b;
    logic [GENE_W-1:0] eng_out;
    logic              c_wr_en;
    logic [ADDR_W-1:0] c_addr;
    logic [GENE_W-1:0] c_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   child_len;

    modport master (
        input  start, child_id, len_a, len_b, a_rdata, b_rdata, eng_read_a, eng_read_b, eng_out,
        output a_rd_en, a_addr, b_rd_en, b_addr, eng_rst, eng_id, eng_parent_a, eng_parent_b,
               c_wr_en, c_addr, c_wdata, busy, done, child_len
    );

    modport slave (
        output start, child_id, len_a, len_b, a_rdata, b_rdata, eng_read_a, eng_read_b, eng_out,
        input  a_rd_en, a_addr, b_rd_en, b_addr, eng_rst, eng_id, eng_parent_a, eng_parent_b,
               c_wr_en, c_addr, c_wdata, busy, done, child_len
    );
endinterface

// File: rtl/eve_gene_ptr.sv
// Parent read pointer capped at a captured length; increments are dropped once exhausted.
// Latency: pointer moves the cycle after inc; no flow control.
module eve_gene_ptr #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic [ADDR_W:0]   len,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              exhausted
);
    logic [ADDR_W:0] ptr;
    logic [ADDR_W:0] len_q;

    assign exhausted = (ptr == len_q);
    assign addr      = ptr[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            len_q <= '0;
        end else if (init) begin
            ptr   <= '0;
            len_q <= len;
        end else if (inc && !exhausted) begin
            ptr <= ptr + (ADDR_W+1)'(1);
        end
    end
endmodule

// File: rtl/eve_crossover_sequencer.sv
// Walks parents A/B through the crossover engine and streams valid child genes to child memory.
// Latency: 4 cycles per engine decision plus 3 cycles start-to-done overhead; no backpressure.
module eve_crossover_sequencer
    import eve_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input logic                       clk,
    input logic                       rst,
    eve_crossover_sequencer_if.master bus
);
    localparam logic [ADDR_W:0] CHILD_MAX = {1'b1, {ADDR_W{1'b0}}};

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              init;
    logic              stall;
    logic              inc_a;
    logic              inc_b;
    logic              exh_a;
    logic              exh_b;
    logic              child_full;
    logic              stall_err;
    logic [7:0]        eng_id_q;
    logic [GENE_W-1:0] parent_a_q;
    logic [GENE_W-1:0] parent_b_q;
    logic              c_wr_en_q;
    logic [ADDR_W-1:0] c_addr_q;
    logic [GENE_W-1:0] c_wdata_q;
    logic [ADDR_W:0]   child_len_q;

    assign init       = (state == ST_IDLE) && bus.start;
    assign stall      = (state == ST_ADVANCE) && !bus.eng_read_a && !bus.eng_read_b;
    assign child_full = (child_len_q == CHILD_MAX);

    // A stalled engine still makes progress: A first, B once A is drained.
    always_comb begin
        inc_a = 1'b0;
        inc_b = 1'b0;
        if (state == ST_ADVANCE) begin
            if (stall) begin
                inc_a = !exh_a;
                inc_b = exh_a;
            end else begin
                inc_a = bus.eng_read_a;
                inc_b = bus.eng_read_b;
            end
        end
    end

    eve_gene_ptr #(.ADDR_W(ADDR_W)) u_ptr_a (
        .clk(clk), .rst(rst), .init(init), .len(bus.len_a), .inc(inc_a),
        .addr(bus.a_addr), .exhausted(exh_a)
    );

    eve_gene_ptr #(.ADDR_W(ADDR_W)) u_ptr_b (
        .clk(clk), .rst(rst), .init(init), .len(bus.len_b), .inc(inc_b),
        .addr(bus.b_addr), .exhausted(exh_b)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.a_rd_en = 1'b0;
        bus.b_rd_en = 1'b0;
        bus.eng_rst = 1'b0;
        bus.busy    = 1'b1;
        bus.done    = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.eng_rst = 1'b1;
                bus.busy    = 1'b0;
                if (bus.start) state_nxt = ST_RESYNC;
            end
            ST_RESYNC: begin
                bus.eng_rst = 1'b1;
                state_nxt   = ST_FETCH;
            end
            ST_FETCH: begin
                if (exh_a && exh_b) begin
                    state_nxt = ST_FINISH;
                end else begin
                    bus.a_rd_en = !exh_a;
                    bus.b_rd_en = !exh_b;
                    state_nxt   = ST_LOAD;
                end
            end
            ST_LOAD:    state_nxt = ST_EVAL;
            ST_EVAL:    state_nxt = ST_ADVANCE;
            ST_ADVANCE: state_nxt = ST_FETCH;
            ST_FINISH: begin
                bus.busy  = 1'b0;
                bus.done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_id_q    <= '0;
            parent_a_q  <= END_GENE;
            parent_b_q  <= END_GENE;
            c_wr_en_q   <= 1'b0;
            c_addr_q    <= '0;
            c_wdata_q   <= '0;
            child_len_q <= '0;
            stall_err   <= 1'b0;
        end else begin
            c_wr_en_q <= 1'b0;
            if (init) begin
                eng_id_q    <= bus.child_id;
                child_len_q <= '0;
                stall_err   <= 1'b0;
            end
            if (state == ST_LOAD) begin
                parent_a_q <= exh_a ? END_GENE : bus.a_rdata;
                parent_b_q <= exh_b ? END_GENE : bus.b_rdata;
            end
            if (state == ST_ADVANCE) begin
                if (stall) stall_err <= 1'b1;
                // Child memory full: further valid genes are dropped, length saturates.
                if (gene_id(bus.eng_out) != INVALID_ID && !child_full) begin
                    c_wr_en_q   <= 1'b1;
                    c_addr_q    <= child_len_q[ADDR_W-1:0];
                    c_wdata_q   <= bus.eng_out;
                    child_len_q <= child_len_q + (ADDR_W+1)'(1);
                end
            end
        end
    end

    assign bus.eng_id       = eng_id_q;
    assign bus.eng_parent_a = parent_a_q;
    assign bus.eng_parent_b = parent_b_q;
    assign bus.c_wr_en      = c_wr_en_q;
    assign bus.c_addr       = c_addr_q;
    assign bus.c_wdata      = c_wdata_q;
    assign bus.child_len    = child_len_q;
endmodule

// File: tb/tb_eve_crossover_sequencer.sv
// Directed bench: parent memories, a node-compare engine model and a child write log around the sequencer.
module tb_eve_crossover_sequencer;
    import eve_pkg::*;

    localparam int AW = 2;

    logic clk;
    logic rst;
    logic stall_mode;
    int   n_tests;
    int   n_fail;
    int   adv_cnt;

    eve_crossover_sequencer_if #(.ADDR_W(AW)) bus ();

    eve_crossover_sequencer #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0]   mem_a [4];
    logic [63:0]   mem_b [4];
    logic [AW-1:0] wr_addr_q [$];
    logic [63:0]   wr_data_q [$];
    logic [63:0]   pa_q [$];
    logic [63:0]   pb_q [$];

    always @(posedge clk) begin
        if (bus.a_rd_en) bus.a_rdata <= mem_a[bus.a_addr];
        if (bus.b_rd_en) bus.b_rdata <= mem_b[bus.b_addr];
    end

    // Engine model: lower node wins; equal nodes merge taking A; B-only genes with ID FF are skipped.
    logic [7:0] node_a;
    logic [7:0] node_b;
    always_comb begin
        node_a         = bus.eng_parent_a[47:40];
        node_b         = bus.eng_parent_b[47:40];
        bus.eng_read_a = 1'b0;
        bus.eng_read_b = 1'b0;
        bus.eng_out    = {INVALID_ID, 56'h0};
        if (node_a == node_b) begin
            bus.eng_read_a = 1'b1;
            bus.eng_read_b = 1'b1;
            bus.eng_out    = {bus.eng_id, bus.eng_parent_a[55:0]};
        end else if (node_a < node_b) begin
            bus.eng_read_a = 1'b1;
            bus.eng_out    = {bus.eng_id, bus.eng_parent_a[55:0]};
        end else begin
            bus.eng_read_b = 1'b1;
            bus.eng_out    = (bus.eng_parent_b[63:56] == INVALID_ID) ? bus.eng_parent_b
                                                                     : {bus.eng_id, bus.eng_parent_b[55:0]};
        end
        if (stall_mode) begin
            bus.eng_read_a = 1'b0;
            bus.eng_read_b = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.c_wr_en) begin
            wr_addr_q.push_back(bus.c_addr);
            wr_data_q.push_back(bus.c_wdata);
        end
        if (dut.state == ST_ADVANCE) begin
            adv_cnt++;
            pa_q.push_back(bus.eng_parent_a);
            pb_q.push_back(bus.eng_parent_b);
        end
    end

    typedef struct {
        string           name;
        logic [7:0]      cid;
        logic [AW:0]     len_a;
        logic [AW:0]     len_b;
        logic [3:0][63:0] a;
        logic [3:0][63:0] b;
        bit              stall;
        int              exp_done;
        int              exp_adv;
        int              exp_nw;
        logic [AW:0]     exp_len;
        logic [4:0][63:0] exp_w;
        bit              exp_stall;
    } vec_t;

    vec_t vt [6];

    function automatic logic [63:0] mk(input logic [7:0] id, input logic [7:0] node, input logic [31:0] data);
        return {id, 1'b0, 7'h00, node, 8'h00, data};
    endfunction

    function automatic logic [63:0] stamp(input logic [7:0] id, input logic [63:0] g);
        return {id, g[55:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic setv(input int i, input string nm, input logic [7:0] cid, input int la, input int lb,
                        input bit st, input int dn, input int adv, input int nw, input int cl, input bit est);
        vt[i].name = nm;          vt[i].cid = cid;
        vt[i].len_a = (AW+1)'(la); vt[i].len_b = (AW+1)'(lb);
        vt[i].stall = st;          vt[i].exp_done = dn;
        vt[i].exp_adv = adv;       vt[i].exp_nw = nw;
        vt[i].exp_len = (AW+1)'(cl); vt[i].exp_stall = est;
        vt[i].a = '0; vt[i].b = '0; vt[i].exp_w = '0;
    endtask

    task automatic launch(input int i);
        for (int j = 0; j < 4; j++) begin
            mem_a[j] = vt[i].a[j];
            mem_b[j] = vt[i].b[j];
        end
        stall_mode = vt[i].stall;
        wr_addr_q.delete(); wr_data_q.delete(); pa_q.delete(); pb_q.delete();
        adv_cnt = 0;
        bus.start = 1'b1; bus.child_id = vt[i].cid; bus.len_a = vt[i].len_a; bus.len_b = vt[i].len_b;
        @(negedge clk);
        bus.start = 1'b0; bus.child_id = 8'h00; bus.len_a = '0; bus.len_b = '0;
    endtask

    task automatic run_vec(input int i, input bit poke);
        int cyc;
        launch(i);
        cyc = 1;
        chk($sformatf("%s.busy_early", vt[i].name), bus.busy, 1);
        while (!bus.done && cyc < 200) begin
            // A start while busy must not disturb the run in flight.
            if (poke && cyc == 2) begin
                bus.start = 1'b1; bus.child_id = 8'hEE; bus.len_a = 3'd1; bus.len_b = 3'd1;
            end else begin
                bus.start = 1'b0; bus.child_id = 8'h00; bus.len_a = '0; bus.len_b = '0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk($sformatf("%s.done_latency", vt[i].name), cyc, vt[i].exp_done);
        chk($sformatf("%s.busy_at_done", vt[i].name), bus.busy, 0);
        if (!bus.done) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("%s.done_one_cycle", vt[i].name), bus.done, 0);
        chk($sformatf("%s.child_len", vt[i].name), bus.child_len, vt[i].exp_len);
        chk($sformatf("%s.n_writes", vt[i].name), wr_data_q.size(), vt[i].exp_nw);
        chk($sformatf("%s.n_advance", vt[i].name), adv_cnt, vt[i].exp_adv);
        chk($sformatf("%s.stall_err", vt[i].name), dut.stall_err, vt[i].exp_stall);
        for (int j = 0; j < vt[i].exp_nw && j < wr_data_q.size(); j++) begin
            chk($sformatf("%s.w%0d_addr", vt[i].name, j), wr_addr_q[j], j);
            chk($sformatf("%s.w%0d_data", vt[i].name, j), wr_data_q[j], vt[i].exp_w[j]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen;
        n_tests = 0; n_fail = 0; adv_cnt = 0; stall_mode = 1'b0;
        rst = 1'b1; bus.start = 1'b0; bus.child_id = 8'h00; bus.len_a = '0; bus.len_b = '0;

        setv(0, "ident", 8'h05, 2, 2, 0, 11, 2, 2, 2, 0);
        vt[0].a[0] = mk(8'h01, 8'd1, 32'hA0A0_0001); vt[0].a[1] = mk(8'h02, 8'd2, 32'hA0A0_0002);
        vt[0].b[0] = mk(8'h11, 8'd1, 32'hB0B0_0001); vt[0].b[1] = mk(8'h12, 8'd2, 32'hB0B0_0002);
        vt[0].exp_w[0] = stamp(8'h05, vt[0].a[0]);   vt[0].exp_w[1] = stamp(8'h05, vt[0].a[1]);

        setv(1, "disjoint", 8'h07, 2, 2, 0, 15, 3, 2, 2, 0);
        vt[1].a[0] = mk(8'h01, 8'd1, 32'h1111_0001); vt[1].a[1] = mk(8'h02, 8'd3, 32'h1111_0003);
        vt[1].b[0] = mk(8'h11, 8'd1, 32'h2222_0001); vt[1].b[1] = mk(8'hFF, 8'd2, 32'h2222_0002);
        vt[1].exp_w[0] = stamp(8'h07, vt[1].a[0]);   vt[1].exp_w[1] = stamp(8'h07, vt[1].a[1]);

        setv(2, "empty_a", 8'h09, 0, 3, 0, 15, 3, 0, 0, 0);
        vt[2].b[0] = mk(8'hFF, 8'd1, 32'h3); vt[2].b[1] = mk(8'hFF, 8'd2, 32'h4); vt[2].b[2] = mk(8'hFF, 8'd3, 32'h5);

        setv(3, "both_zero", 8'h0B, 0, 0, 0, 3, 0, 0, 0, 0);

        setv(4, "stall", 8'h0A, 1, 1, 1, 11, 2, 2, 2, 1);
        vt[4].a[0] = mk(8'h01, 8'd1, 32'hCAFE_0001); vt[4].b[0] = mk(8'h11, 8'd1, 32'hBEEF_0001);
        vt[4].exp_w[0] = stamp(8'h0A, vt[4].a[0]);   vt[4].exp_w[1] = stamp(8'h0A, vt[4].b[0]);

        setv(5, "overflow", 8'h0C, 4, 1, 0, 23, 5, 4, 4, 0);
        for (int j = 0; j < 4; j++) begin
            vt[5].a[j]     = mk(8'(j + 1), 8'(j + 1), 32'hD000_0000 + j);
            vt[5].exp_w[j] = stamp(8'h0C, vt[5].a[j]);
        end
        vt[5].b[0] = mk(8'h21, 8'd5, 32'hE000_0005);

        repeat (3) @(negedge clk);
        chk("reset.busy", bus.busy, 0);
        chk("reset.done", bus.done, 0);
        chk("reset.eng_rst", bus.eng_rst, 1);
        chk("reset.parent_a", bus.eng_parent_a, END_GENE);
        chk("reset.parent_b", bus.eng_parent_b, END_GENE);
        chk("reset.c_wr_en", bus.c_wr_en, 0);
        chk("reset.child_len", bus.child_len, 0);
        chk("reset.rd_en", {bus.a_rd_en, bus.b_rd_en}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, i == 0);
            if (i == 1) chk("disjoint.b_end_held", pb_q.size() > 2 ? pb_q[2] : 64'h0, END_GENE);
            if (i == 2) chk("empty_a.a_end_held", pa_q.size() > 0 ? pa_q[0] : 64'h0, END_GENE);
            if (i == 4) chk("stall.a_forced", pa_q.size() > 1 ? pa_q[1] : 64'h0, END_GENE);
        end

        // Abort during EVAL of the second gene pair.
        launch(0);
        k = 0;
        while (!(dut.state == ST_EVAL && adv_cnt == 1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid.reached_eval2", k < 100, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.busy", bus.busy, 0);
        chk("rst_mid.done", bus.done, 0);
        chk("rst_mid.eng_rst", bus.eng_rst, 1);
        chk("rst_mid.c_wr_en", bus.c_wr_en, 0);
        chk("rst_mid.writes", wr_data_q.size(), 1);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("rst_mid.no_done", seen, 0);
        run_vec(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
